// File: rtl/input_debounce_sync.sv
// ---------------------------------------------------------------------------
// input_debounce_sync
//
// Turns one asynchronous, possibly bouncing external level (link/interrupt
// pin, strap, button) into a clean level in the clk domain. The clean level
// drives a downstream positive edge detector, so every qualified low-to-high
// transition yields exactly one edge there.
//
// Structure:
//   1. SYNC_STAGES-flop synchronizer. Only its last stage (sync_q) is used.
//   2. Two-state qualifier (STABLE / QUALIFY). clean_out only follows sync_q
//      after DEBOUNCE_CYCLES consecutive mismatching edges.
//   3. Saturating glitch counter. It counts qualifications that were aborted
//      because sync_q bounced back to clean_out. This is a link-quality
//      diagnostic.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst         in   asynchronous reset, active-high
//   async_in    in   raw asynchronous level, no timing relation to clk
//   glitch_clr  in   synchronous clear of glitch_cnt; beats an increment
//   clean_out   out  debounced, synchronized level (flop output)
//   busy        out  high exactly while the qualifier is in QUALIFY
//   glitch_cnt  out  saturating count of aborted qualifications
//
// Handshake: none. This is a level-conditioning block with no valid/ready
// interface. busy is the externally visible decode of the qualifier state.
// ---------------------------------------------------------------------------
module input_debounce_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0,
  parameter int   CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             async_in,
  input  logic             glitch_clr,
  output logic             clean_out,
  output logic             busy,
  output logic [CNT_W-1:0] glitch_cnt
);

  // Qualify counter width holds 0..DEBOUNCE_CYCLES.
  localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [QW-1:0]    QCNT_LAST  = QW'(DEBOUNCE_CYCLES - 1);
  localparam logic [QW-1:0]    QCNT_ONE   = QW'(1);
  localparam logic [CNT_W-1:0] GLITCH_MAX = '1;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Synchronizer: a plain shift chain with no logic between stages. Index 0
  // is the first flop. The top index is the metastability-settled output.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_q = sync_chain[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Qualifier state machine
  // -------------------------------------------------------------------------
  state_t          state_q;
  state_t          state_d;
  logic [QW-1:0]   qcnt_q;
  logic [QW-1:0]   qcnt_d;
  logic            clean_d;
  logic            glitch_inc;
  logic            mismatch;

  assign mismatch = (sync_q != clean_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STABLE;
      qcnt_q    <= '0;
      clean_out <= RESET_LEVEL;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      clean_out <= clean_d;
      // busy is registered alongside the state so it is exactly the decode
      // of the state register and never glitches.
      busy      <= (state_d == ST_QUALIFY);
    end
  end

  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    clean_d    = clean_out;
    glitch_inc = 1'b0;

    case (state_q)
      ST_STABLE: begin
        qcnt_d = '0;
        if (mismatch) begin
          if (DEBOUNCE_CYCLES == 1) begin
            // A single mismatching edge is enough. Accept it right away and
            // never enter QUALIFY.
            clean_d = sync_q;
          end else begin
            // This edge is the first of the required consecutive mismatches.
            qcnt_d  = QCNT_ONE;
            state_d = ST_QUALIFY;
          end
        end
      end

      ST_QUALIFY: begin
        if (mismatch) begin
          if (qcnt_q == QCNT_LAST) begin
            clean_d = sync_q;
            qcnt_d  = '0;
            state_d = ST_STABLE;
          end else begin
            qcnt_d = qcnt_q + QCNT_ONE;
          end
        end else begin
          // sync_q bounced back before qualifying. Drop the attempt and count
          // it as a glitch.
          qcnt_d     = '0;
          state_d    = ST_STABLE;
          glitch_inc = 1'b1;
        end
      end

      default: begin
        qcnt_d  = '0;
        state_d = ST_STABLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Glitch counter: saturates, never wraps. A clear wins over a simultaneous
  // abort.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (glitch_inc && (glitch_cnt != GLITCH_MAX)) begin
      glitch_cnt <= glitch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_input_debounce_sync.sv
// ---------------------------------------------------------------------------
// tb_input_debounce_sync
//
// Drives a default-parameter instance (SYNC_STAGES=2, DEBOUNCE_CYCLES=16)
// and a DEBOUNCE_CYCLES=1 instance. When stimulus is driven, each expected
// clean_out transition is pushed to exp_q as {level, edge number}. The
// monitor pops an entry and compares it whenever clean_out changes. Glitch
// counts come from a small saturating model.
// ---------------------------------------------------------------------------
module tb_input_debounce_sync;

  localparam int CNT_W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT
  logic             async_in;
  logic             glitch_clr;
  logic             clean_out;
  logic             busy;
  logic [CNT_W-1:0] glitch_cnt;

  input_debounce_sync #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .RESET_LEVEL(1'b0), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .async_in(async_in), .glitch_clr(glitch_clr),
    .clean_out(clean_out), .busy(busy), .glitch_cnt(glitch_cnt)
  );

  // DEBOUNCE_CYCLES = 1 variant
  logic       async_in2;
  logic       glitch_clr2;
  logic       clean_out2;
  logic       busy2;
  logic [3:0] glitch_cnt2;

  input_debounce_sync #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0), .CNT_W(4)
  ) u_dut_d1 (
    .clk(clk), .rst(rst), .async_in(async_in2), .glitch_clr(glitch_clr2),
    .clean_out(clean_out2), .busy(busy2), .glitch_cnt(glitch_cnt2)
  );

  // scoreboard
  logic [32:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_glitch = 0;
  int t0;
  logic prev_clean = 1'b0;
  logic busy2_seen = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi_cycles, input int lo_cycles);
    async_in = 1'b1;
    repeat (hi_cycles) step();
    async_in = 1'b0;
    repeat (lo_cycles) step();
  endtask

  task automatic note_glitch();
    if (exp_glitch < (1 << CNT_W) - 1) exp_glitch++;
  endtask

  // monitor: every clean_out change must match the head of exp_q
  always @(negedge clk) begin
    if (rst) begin
      prev_clean = clean_out;
    end else if (clean_out !== prev_clean) begin
      if (exp_q.size() == 0) begin
        check_val("unexp_edge", {31'd0, clean_out, 32'(cyc)},
                  {31'd0, prev_clean, 32'(cyc)});
      end else begin
        check_val("clean_edge", {31'd0, clean_out, 32'(cyc)},
                  {31'd0, exp_q.pop_front()});
      end
      prev_clean = clean_out;
    end
    if (busy2) busy2_seen = 1'b1;
  end

  initial begin
    rst = 1'b0; async_in = 1'b0; glitch_clr = 1'b0;
    async_in2 = 1'b0; glitch_clr2 = 1'b0;

    // Asynchronous reset takes effect before any clock edge.
    #1 rst = 1'b1; async_in = 1'b1;
    #1;
    check_val("rst_clean", 64'(clean_out), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_glitch", 64'(glitch_cnt), 64'd0);
    check_val("rst_clean_d1", 64'(clean_out2), 64'd0);

    // Post-reset mismatch: async_in=1 qualifies over the full latency.
    step(); step();
    rst = 1'b0;
    t0 = cyc;
    exp_q.push_back({1'b1, 32'(t0 + 18)});
    for (int e = 1; e <= 18; e++) begin
      step();
      @(negedge clk);
      check_val($sformatf("busy_e%0d", e), 64'(busy),
                64'((e >= 3 && e <= 17) ? 1 : 0));
    end
    check_val("post_rst_high", 64'(clean_out), 64'd1);

    // Clean falling step.
    step();
    t0 = cyc; async_in = 1'b0;
    exp_q.push_back({1'b0, 32'(t0 + 18)});
    repeat (20) step();

    // Clean rising step, with the DEBOUNCE_CYCLES=1 instance in parallel.
    t0 = cyc; async_in = 1'b1; async_in2 = 1'b1;
    exp_q.push_back({1'b1, 32'(t0 + 18)});
    step(); step(); @(negedge clk);
    check_val("d1_rise_early", 64'(clean_out2), 64'd0);
    step(); @(negedge clk);
    check_val("d1_rise", 64'(clean_out2), 64'd1);
    repeat (17) step();

    t0 = cyc; async_in = 1'b0; async_in2 = 1'b0;
    exp_q.push_back({1'b0, 32'(t0 + 18)});
    step(); step(); @(negedge clk);
    check_val("d1_fall_early", 64'(clean_out2), 64'd1);
    step(); @(negedge clk);
    check_val("d1_fall", 64'(clean_out2), 64'd0);
    repeat (17) step();

    // Bounce: 10-cycle pulse is rejected.
    pulse(10, 20); note_glitch();
    check_val("bounce10_glitch", 64'(glitch_cnt), 64'(exp_glitch));
    check_val("bounce10_clean", 64'(clean_out), 64'd0);

    // Boundary: 15 cycles rejected, 16 cycles pass for 16 cycles.
    pulse(15, 25); note_glitch();
    check_val("pulse15_glitch", 64'(glitch_cnt), 64'(exp_glitch));
    t0 = cyc;
    exp_q.push_back({1'b1, 32'(t0 + 18)});
    exp_q.push_back({1'b0, 32'(t0 + 34)});
    pulse(16, 30);
    check_val("pulse16_glitch", 64'(glitch_cnt), 64'(exp_glitch));

    // Clear, then build up to 5.
    glitch_clr = 1'b1; step(); glitch_clr = 1'b0; exp_glitch = 0;
    check_val("clr_glitch", 64'(glitch_cnt), 64'd0);
    repeat (5) begin
      pulse(5, 10); note_glitch();
    end
    check_val("five_glitch", 64'(glitch_cnt), 64'(exp_glitch));

    // Clear on the very edge that aborts a qualification.
    async_in = 1'b1;
    repeat (5) step();
    async_in = 1'b0;
    step(); step(); @(negedge clk);
    check_val("abort_pending_busy", 64'(busy), 64'd1);
    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0; exp_glitch = 0;
    @(negedge clk);
    check_val("clr_prio_glitch", 64'(glitch_cnt), 64'(exp_glitch));
    check_val("clr_prio_busy", 64'(busy), 64'd0);
    repeat (10) step();
    pulse(5, 10); note_glitch();
    check_val("after_clr_glitch", 64'(glitch_cnt), 64'(exp_glitch));

    // Continuous fast toggling: counter saturates, clean_out holds.
    repeat (300) begin
      pulse(3, $urandom_range(5, 8)); note_glitch();
    end
    check_val("sat_glitch", 64'(glitch_cnt), 64'(exp_glitch));
    check_val("sat_clean", 64'(clean_out), 64'd0);

    // Async reset at qualify count 9, between edges.
    async_in = 1'b1;
    repeat (11) step();
    @(negedge clk);
    check_val("midq_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    exp_glitch = 0;
    check_val("midq_rst_clean", 64'(clean_out), 64'd0);
    check_val("midq_rst_busy", 64'(busy), 64'd0);
    check_val("midq_rst_glitch", 64'(glitch_cnt), 64'(exp_glitch));
    step(); step();
    rst = 1'b0;
    t0 = cyc;
    exp_q.push_back({1'b1, 32'(t0 + 18)});
    repeat (20) step();
    check_val("midq_no_glitch", 64'(glitch_cnt), 64'(exp_glitch));
    t0 = cyc; async_in = 1'b0;
    exp_q.push_back({1'b0, 32'(t0 + 18)});
    repeat (20) step();

    // final report
    check_val("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check_val("d1_busy_never", 64'(busy2_seen), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_debounce_sync.md
Name: input_debounce_sync

Overview:
- Conditions one asynchronous, possibly bouncing external level (PHY link/interrupt pin, board strap, button) into a clean, single-clock-domain level.
- Sits directly upstream of the positive edge detector: clean_out drives the detector's sampled input, so every qualified low-to-high transition yields exactly one edge pulse.
- Combines a multi-flop synchronizer, a consecutive-cycle debounce qualifier and a saturating glitch counter for link-quality diagnostics.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range >= 2.
- DEBOUNCE_CYCLES, 16, consecutive mismatching cycles required before clean_out changes; legal range >= 1.
- RESET_LEVEL, 1'b0, reset value of the synchronizer chain and of clean_out.
- CNT_W, 8, width of glitch_cnt.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- async_in  input  1  raw asynchronous level; no timing relationship to clk.
- glitch_clr  input  1  synchronous clear of glitch_cnt, active-high.
- clean_out  output  1  debounced, synchronized level; feeds the edge detector.
- busy  output  1  high while a transition is being qualified (state QUALIFY).
- glitch_cnt  output  CNT_W  saturating count of aborted qualifications.

Behaviour:
- Reset (async, rst=1), effective immediately and independent of clk:
  - synchronizer flops = RESET_LEVEL; clean_out = RESET_LEVEL.
  - state = STABLE; busy = 0; qualify counter = 0; glitch_cnt = 0.
- Synchronizer:
  - SYNC_STAGES-flop shift chain; sync_q = last stage.
  - No logic between stages.
  - Only sync_q is used by downstream logic.
- Qualify counter:
  - Width $clog2(DEBOUNCE_CYCLES+1).
  - Counts consecutive edges where sync_q != clean_out.
- State machine (two states):
  - STABLE, sync_q == clean_out: hold; counter 0.
  - STABLE, sync_q != clean_out: if DEBOUNCE_CYCLES == 1, clean_out <= sync_q at this edge and stay STABLE. Otherwise counter <= 1 and go to QUALIFY.
  - QUALIFY, sync_q != clean_out, counter == DEBOUNCE_CYCLES-1: clean_out <= sync_q, counter <= 0, go to STABLE.
  - QUALIFY, sync_q != clean_out, otherwise: counter <= counter + 1.
  - QUALIFY, sync_q == clean_out (bounce back): abort; counter <= 0; go to STABLE; glitch_cnt increments.
- Outputs:
  - busy is a registered decode of state: 1 exactly while in QUALIFY.
  - clean_out is a flop output and never glitches.
- Latency:
  - An async_in step meeting setup before edge 1, held stable, appears at sync_q after edge SYNC_STAGES.
  - clean_out changes at edge SYNC_STAGES + DEBOUNCE_CYCLES; 18 edges with defaults.
- Pulse rejection:
  - An input pulse shorter than DEBOUNCE_CYCLES clk periods (after synchronization) never reaches clean_out.
  - Each such pulse that entered QUALIFY counts as one glitch.
- glitch_cnt:
  - Saturates at 2^CNT_W-1; no wrap.
  - glitch_clr=1 sets it to 0 at the next edge.
  - glitch_clr wins over a simultaneous increment.
- Post-reset mismatch: if async_in differs from RESET_LEVEL when rst deasserts, the block qualifies normally and clean_out transitions after the full latency. The downstream detector then sees one legitimate edge.
- Reset mid-qualification: the partial count is discarded, glitch_cnt is cleared and clean_out returns to RESET_LEVEL. The attempt is not counted.
- Continuous toggling faster than DEBOUNCE_CYCLES: clean_out holds indefinitely; glitch_cnt accumulates one per abort.

Test Plan:
- Reset check: rst=1, async_in=1 -> clean_out=0, busy=0, glitch_cnt=0 with no clock edges. Release rst, hold async_in=1 -> clean_out=1 at edge 18, busy high for edges 3..17.
- Clean step: defaults, async_in 0->1 before edge 1 -> clean_out rises at edge 18, not earlier; async_in 1->0 later -> clean_out falls exactly 18 edges after.
- Bounce rejection: async_in high for 10 clk, then low -> clean_out stays 0, glitch_cnt=1. Repeat 300 times with CNT_W=8 -> glitch_cnt saturates at 255.
- Boundary lengths: synchronized high pulse of 15 clk -> rejected, glitch_cnt+1. Pulse of exactly 16 clk -> clean_out high for 16 clk, glitch_cnt unchanged.
- Clear priority: glitch_cnt=5, glitch_clr=1 on the same edge as an abort -> glitch_cnt=0. Next abort -> 1.
- Async reset mid-QUALIFY: assert rst between edges at counter=9 -> clean_out=0, busy=0, glitch_cnt=0 immediately, before the next edge. DEBOUNCE_CYCLES=1 variant: latency equals SYNC_STAGES+1 edges and busy never asserts.
